// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters.
// Optional feature: define ARB_LOCK_EN to add lock_i, which lets the owner
// extend its grant past HOLD cycles while it keeps requesting.
module dff_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
`ifdef ARB_LOCK_EN
  input  logic                     lock_i,
`endif
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*WIDTH-1:0]    wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [$clog2(NREQ)-1:0]  owner_o,
  output logic [WIDTH-1:0]         q_o,
  output logic                     q_valid_o,
  output logic                     busy_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_valid_q, q_valid_d;

  logic [IdxW-1:0]   win;
  logic              found;
  logic              stay;

  // Round-robin pick: first set request scanning upward from ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + off) % NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = IdxW'(idx);
      end
    end
  end

  // Next-state: grant on request from idle, load/count/release while granted.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    stay      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = '0;
          gnt_d[win] = 1'b1;
          owner_d = win;
          cnt_d   = 4'(HOLD - 1);
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (req_i[owner_q]) begin
          q_d       = wdata_i[int'(owner_q)*WIDTH +: WIDTH];
          q_valid_d = 1'b1;
`ifdef ARB_LOCK_EN
          // Lock keeps the grant; the counter still runs down but saturates.
          if (lock_i) begin
            stay  = 1'b1;
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          end else
`endif
          if (cnt_q != 4'd0) begin
            stay  = 1'b1;
            cnt_d = cnt_q - 4'd1;
          end
        end
        if (!stay) begin
          gnt_d   = '0;
          ptr_d   = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + IdxW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset clears everything immediately, even mid-grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Outputs straight from the registers.
  always_comb begin
    gnt_o     = gnt_q;
    owner_o   = owner_q;
    q_o       = q_q;
    q_valid_o = q_valid_q;
    busy_o    = (state_q == StGrant);
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8, HOLD=2).
// Compares every cycle against a grant-level reference model.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic        clk;
  logic        rst_n;
  logic        lock;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: current grantee (-1 = none), cycles of grant left, pointer.
  int          m_g;
  int          m_owner;
  int          m_ptr;
  int          m_left;
  logic [7:0]  m_q;
  logic        m_qv;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
`ifdef ARB_LOCK_EN
    .lock_i    (lock),
`endif
    .req_i     (req),
    .wdata_i   (wdata),
    .gnt_o     (gnt),
    .owner_o   (owner),
    .q_o       (q),
    .q_valid_o (q_valid),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_owner = 0; m_ptr = 0; m_left = 0; m_q = 8'h00; m_qv = 1'b0;
  endtask

  task automatic model_edge();
    bit keep;
    if (m_g < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (m_g < 0 && req[i]) begin
          m_g = i; m_owner = i; m_left = HOLD;
        end
      end
    end else begin
      keep = 1'b0;
      if (req[m_owner]) begin
        m_q  = wdata[m_owner*WIDTH +: WIDTH];
        m_qv = 1'b1;
`ifdef ARB_LOCK_EN
        if (lock) begin
          keep   = 1'b1;
          m_left = (m_left > 1) ? m_left - 1 : 1;
        end else
`endif
        begin
          m_left = m_left - 1;
          keep   = (m_left > 0);
        end
      end
      if (!keep) begin
        m_g   = -1;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
    check({tag, ".gnt"},     gnt,     eg);
    check({tag, ".owner"},   owner,   m_owner);
    check({tag, ".q"},       q,       m_q);
    check({tag, ".q_valid"}, q_valid, m_qv);
    check({tag, ".busy"},    busy,    (m_g >= 0));
  endtask

  // One clock: inputs already driven; update the model at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    lock  = 1'b0;
    req   = 4'b0000;
    wdata = 32'h44332211;
    model_reset();

    // 1: reset held, then released with no requests
    step("rst0");
    step("rst1");
    #2 rst_n = 1'b1;
    step("idle0");
    step("idle1");
    check("t1.q_literal", q, 8'h00);

    // 2: single requester held
    req = 4'b0100;
    for (int i = 0; i < 5; i++) step("single");
    check("t2.q_literal", q, 8'h33);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step("drain2");

    // 3: all requesting, rotation
    req = 4'b1111;
    for (int i = 0; i < 16; i++) step("rr");
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step("drain3");

    // 4: requester drops during its first grant cycle
    req = 4'b0010;
    step("drop.grant");
    req = 4'b0000;
    step("drop.release");
    req = 4'b1111;
    step("drop.next");
    check("t4.owner_after_drop", owner, 2'd2);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step("drain4");

    // 5: asynchronous reset mid-grant
    req = 4'b0001;
    step("ar.grant");
    step("ar.load");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ar.immediate");
    req = 4'b0000;
    step("ar.held");
    #2 rst_n = 1'b1;
    req = 4'b1000;
    step("ar.after");
    check("t5.owner3", owner, 2'd3);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step("drain5");

`ifdef ARB_LOCK_EN
    // 6: lock extends the grant, release one edge after lock drops
    req  = 4'b0001;
    lock = 1'b1;
    for (int i = 0; i < 5; i++) step("lock");
    lock = 1'b0;
    step("unlock");
    req = 4'b0000;
    for (int i = 0; i < 2; i++) step("drain6");
`endif

    // Randomised traffic with sticky requests and changing data
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      wdata = $urandom;
`ifdef ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
